axil_slave_regs: RTL and testbench

AXIL_SLAVE_REGS -- requirements
Module: axil_slave_regs

---
 rtl/axil_regs_pkg.sv | 16 +
 rtl/axil_slave_regs.sv | 192 +++++++++++++++++++
 tb/tb_axil_slave_regs.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_regs_pkg.sv
// Shared constants and types for the AXI4-Lite register slave.
package axil_regs_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_IRQ_EN   = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_IRQ_FLAG = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axil_slave_regs.sv
// AXI4-Lite slave with four word registers: CTRL, IRQ_EN, STATUS (read-only)
// and IRQ_FLAG (write-one-to-clear), plus a registered interrupt output.
module axil_slave_regs
  import axil_regs_pkg::*;
#(
  parameter int AddrW = 4,
  parameter int DataW = 32,
  parameter int StrbW = DataW / 8
) (
  input  logic             clk,
  input  logic             reset,
  // AW channel
  input  logic [AddrW-1:0] axi_awaddr,
  input  logic             axi_awvalid,
  output logic             axi_awreadyo,
  // W channel
  input  logic [DataW-1:0] axi_wdata,
  input  logic [StrbW-1:0] axi_wstrb,
  input  logic             axi_wvalid,
  output logic             axi_wreadyo,
  // B channel
  output logic             axi_bvalido,
  input  logic             axi_bready,
  output logic [1:0]       axi_brespo,
  // AR channel
  input  logic [AddrW-1:0] axi_araddr,
  input  logic             axi_arvalid,
  output logic             axi_arreadyo,
  // R channel
  output logic [DataW-1:0] axi_rdatao,
  output logic [1:0]       axi_rrespo,
  output logic             axi_rvalido,
  input  logic             axi_rready,
  // user side
  output logic [DataW-1:0] ctrlo,
  input  logic [DataW-1:0] stat,
  input  logic [DataW-1:0] irq_set,
  output logic             irqo
);

  function automatic logic [DataW-1:0] strb_mask(input logic [StrbW-1:0] strb);
    logic [DataW-1:0] mask;
    mask = '0;
    for (int i = 0; i < StrbW; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  logic             aw_held_q, aw_held_d;
  logic [1:0]       awidx_q, awidx_d;
  logic             w_held_q, w_held_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0] wstrb_q, wstrb_d;
  logic             bvalid_q, bvalid_d;
  logic [DataW-1:0] ctrl_q, ctrl_d;
  logic [DataW-1:0] irq_en_q, irq_en_d;
  logic [DataW-1:0] irq_flag_q, irq_flag_d;
  logic             irq_q, irq_d;
  rd_state_e        rstate_q, rstate_d;
  logic [DataW-1:0] rdata_q, rdata_d;

  logic             aw_hs, w_hs, commit;
  logic [1:0]       wr_idx, rd_idx;
  logic [DataW-1:0] wr_data, wr_mask, flag_clr, rd_val;

  // Only the word index addr[3:2] is decoded; the remaining address bits are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_awaddr, axi_araddr};

  assign axi_awreadyo = !aw_held_q && !bvalid_q;
  assign axi_wreadyo  = !w_held_q && !bvalid_q;
  assign aw_hs        = axi_awvalid && axi_awreadyo;
  assign w_hs         = axi_wvalid && axi_wreadyo;

  // A write commits as soon as both halves are available, whether held or arriving now.
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_idx  = aw_held_q ? awidx_q : axi_awaddr[3:2];
  assign wr_data = w_held_q ? wdata_q : axi_wdata;
  assign wr_mask = strb_mask(w_held_q ? wstrb_q : axi_wstrb);

  assign rd_idx = axi_araddr[3:2];

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      REG_CTRL:     rd_val = ctrl_q;
      REG_IRQ_EN:   rd_val = irq_en_q;
      REG_STATUS:   rd_val = stat;
      REG_IRQ_FLAG: rd_val = irq_flag_q;
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    aw_held_d = aw_held_q;
    awidx_d   = awidx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    ctrl_d    = ctrl_q;
    irq_en_d  = irq_en_q;
    flag_clr  = '0;
    rstate_d  = rstate_q;
    rdata_d   = rdata_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awidx_d   = axi_awaddr[3:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = axi_wdata;
      wstrb_d  = axi_wstrb;
    end
    if (bvalid_q && axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (wr_idx)
        REG_CTRL:     ctrl_d   = (ctrl_q & ~wr_mask) | (wr_data & wr_mask);
        REG_IRQ_EN:   irq_en_d = (irq_en_q & ~wr_mask) | (wr_data & wr_mask);
        REG_IRQ_FLAG: flag_clr = wr_data & wr_mask;
        default:      ;
      endcase
    end

    // Set is OR-ed in after the clear so a coincident pulse wins.
    irq_flag_d = (irq_flag_q & ~flag_clr) | irq_set;
    irq_d      = |(irq_flag_q & irq_en_q);

    case (rstate_q)
      R_IDLE: begin
        if (axi_arvalid) begin
          rdata_d  = rd_val;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi_rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held_q  <= 1'b0;
      awidx_q    <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      ctrl_q     <= '0;
      irq_en_q   <= '0;
      irq_flag_q <= '0;
      irq_q      <= 1'b0;
      rstate_q   <= R_IDLE;
      rdata_q    <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      awidx_q    <= awidx_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      ctrl_q     <= ctrl_d;
      irq_en_q   <= irq_en_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
      rstate_q   <= rstate_d;
      rdata_q    <= rdata_d;
    end
  end

  assign axi_bvalido  = bvalid_q;
  assign axi_brespo   = RESP_OKAY;
  assign axi_arreadyo = (rstate_q == R_IDLE);
  assign axi_rvalido  = (rstate_q == R_DATA);
  assign axi_rdatao   = rdata_q;
  assign axi_rrespo   = RESP_OKAY;
  assign ctrlo        = ctrl_q;
  assign irqo         = irq_q;

endmodule

// File: tb/tb_axil_slave_regs.sv
// Scenario bench for axil_slave_regs: expected responses queue up when a
// request is driven and are popped when the slave answers.
module tb_axil_slave_regs;
  import axil_regs_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  axi_awaddr;
  logic        axi_awvalid, axi_awreadyo;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid, axi_wreadyo;
  logic        axi_bvalido, axi_bready;
  logic [1:0]  axi_brespo;
  logic [3:0]  axi_araddr;
  logic        axi_arvalid, axi_arreadyo;
  logic [31:0] axi_rdatao;
  logic [1:0]  axi_rrespo;
  logic        axi_rvalido, axi_rready;
  logic [31:0] ctrlo, stat, irq_set;
  logic        irqo;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [1:0]  b_q[$];
  logic [31:0] r_q[$];

  always #5 clk = ~clk;

  axil_slave_regs #(.AddrW(4), .DataW(32)) dut (
    .clk(clk), .reset(reset),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awreadyo(axi_awreadyo),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wreadyo(axi_wreadyo),
    .axi_bvalido(axi_bvalido), .axi_bready(axi_bready), .axi_brespo(axi_brespo),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arreadyo(axi_arreadyo),
    .axi_rdatao(axi_rdatao), .axi_rrespo(axi_rrespo), .axi_rvalido(axi_rvalido),
    .axi_rready(axi_rready),
    .ctrlo(ctrlo), .stat(stat), .irq_set(irq_set), .irqo(irqo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives AW and W with independent start delays, then consumes the B response.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_delay, input int w_delay,
                          input string name);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int cyc = 0;
    int wait_cyc = 0;
    logic [1:0] want;
    b_q.push_back(RESP_OKAY);
    while (!(aw_done && w_done) && cyc < 50) begin
      axi_awaddr  = addr;
      axi_wdata   = data;
      axi_wstrb   = strb;
      axi_awvalid = !aw_done && (cyc >= aw_delay);
      axi_wvalid  = !w_done && (cyc >= w_delay);
      aw_fire     = axi_awvalid && axi_awreadyo;
      w_fire      = axi_wvalid && axi_wreadyo;
      tick();
      aw_done |= aw_fire;
      w_done  |= w_fire;
      cyc++;
    end
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    while (!axi_bvalido && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    total_cnt++;
    if (!(aw_done && w_done && axi_bvalido === 1'b1 && wait_cyc == 0)) begin
      $display("FAIL %s_blatency: bvalid=%b after %0d extra cycles, handshakes aw=%0d w=%0d, required bvalid=1 one cycle after commit",
               name, axi_bvalido, wait_cyc, aw_done, w_done);
    end else pass_cnt++;
    want = b_q.pop_front();
    total_cnt++;
    if (axi_brespo !== want || axi_awreadyo !== 1'b0 || axi_wreadyo !== 1'b0) begin
      $display("FAIL %s_bresp: bresp=%b awready=%b wready=%b, required bresp=%b awready=0 wready=0",
               name, axi_brespo, axi_awreadyo, axi_wreadyo, want);
    end else pass_cnt++;
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    total_cnt++;
    if (axi_bvalido !== 1'b0 || axi_awreadyo !== 1'b1 || axi_wreadyo !== 1'b1) begin
      $display("FAIL %s_brelease: bvalid=%b awready=%b wready=%b, required 0/1/1",
               name, axi_bvalido, axi_awreadyo, axi_wreadyo);
    end else pass_cnt++;
  endtask

  // Issues one read, holds rready low for 'hold' cycles, then takes the data.
  task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input int hold,
                         input string name);
    logic [31:0] first, want;
    r_q.push_back(exp);
    axi_araddr  = addr;
    axi_arvalid = 1'b1;
    total_cnt++;
    if (axi_arreadyo !== 1'b1) begin
      $display("FAIL %s_arready: arready=%b, required 1", name, axi_arreadyo);
    end else pass_cnt++;
    tick();
    axi_arvalid = 1'b0;
    total_cnt++;
    if (axi_rvalido !== 1'b1) begin
      $display("FAIL %s_rlatency: rvalid=%b one cycle after AR, required 1", name, axi_rvalido);
    end else pass_cnt++;
    first = axi_rdatao;
    for (int i = 0; i < hold; i++) begin
      tick();
      total_cnt++;
      if (axi_rvalido !== 1'b1 || axi_rdatao !== first || axi_arreadyo !== 1'b0) begin
        $display("FAIL %s_rstall: cycle %0d rvalid=%b rdata=%h arready=%b, required 1/%h/0",
                 name, i, axi_rvalido, axi_rdatao, axi_arreadyo, first);
      end else pass_cnt++;
    end
    want = r_q.pop_front();
    total_cnt++;
    if (axi_rdatao !== want || axi_rrespo !== RESP_OKAY) begin
      $display("FAIL %s_rdata: rdata=%h rresp=%b, required %h/00", name, axi_rdatao, axi_rrespo, want);
    end else pass_cnt++;
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    total_cnt++;
    if (axi_rvalido !== 1'b0 || axi_arreadyo !== 1'b1) begin
      $display("FAIL %s_rrelease: rvalid=%b arready=%b, required 0/1", name, axi_rvalido, axi_arreadyo);
    end else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total_cnt++;
    if (axi_awreadyo !== 1'b1 || axi_wreadyo !== 1'b1 || axi_arreadyo !== 1'b1) begin
      $display("FAIL reset_ready: aw=%b w=%b ar=%b, required 1/1/1", axi_awreadyo, axi_wreadyo, axi_arreadyo);
    end else pass_cnt++;
    total_cnt++;
    if (axi_bvalido !== 1'b0 || axi_rvalido !== 1'b0 || irqo !== 1'b0) begin
      $display("FAIL reset_valid: bvalid=%b rvalid=%b irqo=%b, required 0/0/0", axi_bvalido, axi_rvalido, irqo);
    end else pass_cnt++;
    total_cnt++;
    if (ctrlo !== 32'h0 || axi_rdatao !== 32'h0) begin
      $display("FAIL reset_data: ctrlo=%h rdata=%h, required 0/0", ctrlo, axi_rdatao);
    end else pass_cnt++;
    do_read(4'h4, 32'h0, 0, "reset_irq_en");
    do_read(4'hC, 32'h0, 0, "reset_irq_flag");
  endtask

  task automatic test_write_same_cycle();
    do_write(4'h0, 32'hDEADBEEF, 4'hF, 0, 0, "wr_same");
    total_cnt++;
    if (ctrlo !== 32'hDEADBEEF) begin
      $display("FAIL wr_same_ctrlo: ctrlo=%h, required deadbeef", ctrlo);
    end else pass_cnt++;
    do_read(4'h0, 32'hDEADBEEF, 0, "wr_same_rd");
  endtask

  task automatic test_write_split();
    do_write(4'h4, 32'h0000AB00, 4'b0010, 3, 0, "wr_split");
    tick();
    total_cnt++;
    if (axi_bvalido !== 1'b0) begin
      $display("FAIL wr_split_single: bvalid=%b after response taken, required 0", axi_bvalido);
    end else pass_cnt++;
    do_read(4'h4, 32'h0000AB00, 0, "wr_split_rd");
    do_write(4'h0, 32'h11223344, 4'b0101, 0, 2, "wr_strb");
    total_cnt++;
    if (ctrlo !== 32'hDE22BE44) begin
      $display("FAIL wr_strb_ctrlo: ctrlo=%h, required de22be44", ctrlo);
    end else pass_cnt++;
    do_read(4'h1, 32'hDE22BE44, 1, "rd_alias");
  endtask

  task automatic test_status();
    stat = 32'h12345678;
    do_write(4'h8, 32'hFFFFFFFF, 4'hF, 0, 0, "wr_status");
    do_read(4'h8, 32'h12345678, 5, "rd_status");
  endtask

  task automatic test_irq();
    logic [1:0] want;
    do_write(4'h4, 32'h00000001, 4'hF, 0, 0, "irq_en");
    irq_set = 32'h1;
    tick();
    irq_set = 32'h0;
    total_cnt++;
    if (irqo !== 1'b0) begin
      $display("FAIL irq_delay: irqo=%b in the cycle the flag sets, required 0", irqo);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (irqo !== 1'b1) begin
      $display("FAIL irq_raise: irqo=%b, required 1", irqo);
    end else pass_cnt++;
    // W1C commit in the same cycle as a fresh set pulse on the same bit.
    b_q.push_back(RESP_OKAY);
    axi_awaddr  = 4'hC;
    axi_wdata   = 32'h1;
    axi_wstrb   = 4'hF;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    irq_set     = 32'h1;
    tick();
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    irq_set     = 32'h0;
    want = b_q.pop_front();
    total_cnt++;
    if (axi_bvalido !== 1'b1 || axi_brespo !== want) begin
      $display("FAIL irq_w1c_resp: bvalid=%b bresp=%b, required 1/%b", axi_bvalido, axi_brespo, want);
    end else pass_cnt++;
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    do_read(4'hC, 32'h1, 0, "irq_set_wins");
    total_cnt++;
    if (irqo !== 1'b1) begin
      $display("FAIL irq_hold: irqo=%b, required 1", irqo);
    end else pass_cnt++;
    do_write(4'hC, 32'h1, 4'hF, 0, 0, "irq_clr");
    total_cnt++;
    if (irqo !== 1'b0) begin
      $display("FAIL irq_drop: irqo=%b, required 0", irqo);
    end else pass_cnt++;
    do_read(4'hC, 32'h0, 0, "irq_clr_rd");
    irq_set = 32'h00000101;
    tick();
    irq_set = 32'h0;
    do_write(4'hC, 32'h00000101, 4'b0001, 0, 0, "irq_clr_strb");
    do_read(4'hC, 32'h00000100, 0, "irq_clr_strb_rd");
    total_cnt++;
    if (irqo !== 1'b0) begin
      $display("FAIL irq_masked: irqo=%b with only disabled flag bits set, required 0", irqo);
    end else pass_cnt++;
    do_write(4'hC, 32'hFFFFFFFF, 4'hF, 0, 0, "irq_clr_all");
  endtask

  task automatic test_collision();
    logic [31:0] want_r;
    logic [1:0]  want_b;
    do_write(4'h0, 32'h5, 4'hF, 0, 0, "col_pre");
    r_q.push_back(32'h5);
    b_q.push_back(RESP_OKAY);
    axi_araddr  = 4'h0;
    axi_arvalid = 1'b1;
    axi_awaddr  = 4'h0;
    axi_wdata   = 32'hA;
    axi_wstrb   = 4'hF;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    tick();
    axi_arvalid = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    want_r = r_q.pop_front();
    want_b = b_q.pop_front();
    total_cnt++;
    if (axi_rvalido !== 1'b1 || axi_rdatao !== want_r) begin
      $display("FAIL col_rdata: rvalid=%b rdata=%h, required 1/%h", axi_rvalido, axi_rdatao, want_r);
    end else pass_cnt++;
    total_cnt++;
    if (axi_bvalido !== 1'b1 || axi_brespo !== want_b || ctrlo !== 32'hA) begin
      $display("FAIL col_write: bvalid=%b bresp=%b ctrlo=%h, required 1/%b/0000000a",
               axi_bvalido, axi_brespo, ctrlo, want_b);
    end else pass_cnt++;
    axi_rready = 1'b1;
    axi_bready = 1'b1;
    tick();
    axi_rready = 1'b0;
    axi_bready = 1'b0;
    total_cnt++;
    if (axi_rvalido !== 1'b0 || axi_bvalido !== 1'b0) begin
      $display("FAIL col_release: rvalid=%b bvalid=%b, required 0/0", axi_rvalido, axi_bvalido);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit seen_b;
    logic [1:0] want;
    b_q.push_back(RESP_OKAY);
    axi_awaddr  = 4'h0;
    axi_wdata   = 32'h77;
    axi_wstrb   = 4'hF;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b_q.delete();
    total_cnt++;
    if (axi_bvalido !== 1'b0 || ctrlo !== 32'h0) begin
      $display("FAIL rst_mid_b: bvalid=%b ctrlo=%h after reset, required 0/0", axi_bvalido, ctrlo);
    end else pass_cnt++;
    // A lone held W beat must be dropped by reset.
    axi_wdata  = 32'hBAD0;
    axi_wvalid = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    axi_awaddr  = 4'h0;
    axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    axi_bready  = 1'b1;
    seen_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (axi_bvalido) seen_b = 1'b1;
      tick();
    end
    axi_bready = 1'b0;
    total_cnt++;
    if (seen_b || ctrlo !== 32'h0) begin
      $display("FAIL rst_mid_partial: bvalid_seen=%b ctrlo=%h, required 0/0", seen_b, ctrlo);
    end else pass_cnt++;
    b_q.push_back(RESP_OKAY);
    axi_wdata  = 32'h600D;
    axi_wstrb  = 4'hF;
    axi_wvalid = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    want = b_q.pop_front();
    total_cnt++;
    if (axi_bvalido !== 1'b1 || axi_brespo !== want || ctrlo !== 32'h600D) begin
      $display("FAIL rst_mid_resume: bvalid=%b bresp=%b ctrlo=%h, required 1/%b/0000600d",
               axi_bvalido, axi_brespo, ctrlo, want);
    end else pass_cnt++;
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    axi_rready  = 1'b1;
    axi_arvalid = 1'b1;
    axi_araddr  = 4'h0;
    r_q.push_back(32'h600D);
    tick();
    want = r_q.pop_front();
    total_cnt++;
    if (axi_rvalido !== 1'b1 || axi_rdatao !== want || axi_arreadyo !== 1'b0) begin
      $display("FAIL b2b_first: rvalid=%b rdata=%h arready=%b, required 1/%h/0",
               axi_rvalido, axi_rdatao, axi_arreadyo, want);
    end else pass_cnt++;
    axi_araddr = 4'h4;
    r_q.push_back(32'h0);
    tick();
    total_cnt++;
    if (axi_rvalido !== 1'b0 || axi_arreadyo !== 1'b1) begin
      $display("FAIL b2b_gap: rvalid=%b arready=%b, required 0/1", axi_rvalido, axi_arreadyo);
    end else pass_cnt++;
    tick();
    axi_arvalid = 1'b0;
    want = r_q.pop_front();
    total_cnt++;
    if (axi_rvalido !== 1'b1 || axi_rdatao !== want) begin
      $display("FAIL b2b_second: rvalid=%b rdata=%h, required 1/%h", axi_rvalido, axi_rdatao, want);
    end else pass_cnt++;
    tick();
    axi_rready = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    axi_awaddr  = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_araddr  = '0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    stat        = '0;
    irq_set     = '0;

    test_reset();
    test_write_same_cycle();
    test_write_split();
    test_status();
    test_irq();
    test_collision();
    test_reset_mid();
    test_back_to_back();

    total_cnt++;
    if (b_q.size() != 0 || r_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d write and %0d read expectations left, required 0/0",
               b_q.size(), r_q.size());
    end else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
